// File: rtl/cpu_defs_pkg.sv
// Shared front-end definitions: reset vector, fetch geometry defaults,
// PC-generator state encoding and the redirect bundle.
package cpu_defs_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam logic [CPU_ADDR_W-1:0] PC_RESET_VEC = 32'h1c00_0000;
  localparam int FETCH_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Shared by the exception/ertn and branch redirect sources.
  typedef struct packed {
    logic                  flag;
    logic [CPU_ADDR_W-1:0] target;
  } redirect_t;

  // Slot-offset field width; a one-slot block still carries a 1-bit field.
  function automatic int off_width(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

endpackage

// File: rtl/pc_slot_mask.sv
// Maps the instruction-slot offset of a fetch address to the mask of slots
// at or after it within the fetch block. Also used by predecode.
module pc_slot_mask
  import cpu_defs_pkg::*;
#(
  parameter  int FETCH_WIDTH = FETCH_WIDTH_DEF,
  localparam int OFF_W       = off_width(FETCH_WIDTH)
) (
  input  logic [OFF_W-1:0]       off,
  output logic [FETCH_WIDTH-1:0] slot_mask
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_mask[i] = (FETCH_WIDTH == 1) ? 1'b1 : (OFF_W'(i) >= off);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: one block address per ICache handshake, with
// exception and branch redirects and an IDLE halt left only by exception.
module pc_gen
  import cpu_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = CPU_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = PC_RESET_VEC,
  parameter int                    FETCH_WIDTH = FETCH_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   excp_flag_i,
  input  logic [ADDR_WIDTH-1:0]  excp_target_i,
  input  logic                   branch_flag_i,
  input  logic [ADDR_WIDTH-1:0]  branch_target_i,
  input  logic                   idle_i,
  input  logic                   stall_i,
  input  logic                   ready_i,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   valid_o,
  output logic [FETCH_WIDTH-1:0] slot_mask_o,
  output logic                   adef_o,
  output logic                   halted_o
);

  localparam int OFF_W     = off_width(FETCH_WIDTH);
  localparam int BLK_BYTES = FETCH_WIDTH * 4;
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~(ADDR_WIDTH'(BLK_BYTES - 1));

  pc_state_t             state, next_state;
  logic [ADDR_WIDTH-1:0] pc_q, pc_next, blk_next;
  redirect_t             excp_r, br_r;
  logic                  adv;

  // Redirect bundles are CPU_ADDR_W wide; ADDR_WIDTH must not exceed it.
  assign excp_r = '{flag: excp_flag_i,   target: CPU_ADDR_W'(excp_target_i)};
  assign br_r   = '{flag: branch_flag_i, target: CPU_ADDR_W'(branch_target_i)};

  assign adv      = valid_o & ready_i & ~stall_i;
  assign blk_next = (pc_q & BLK_MASK) + ADDR_WIDTH'(BLK_BYTES);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
    end else begin
      state <= next_state;
      pc_q  <= pc_next;
    end
  end

  // An exception in RUN overrides a simultaneous idle; IDLE only halts otherwise.
  always_comb begin
    next_state = state;
    unique case (state)
      BOOT:    next_state = RUN;
      RUN:     if (!excp_r.flag && idle_i) next_state = HALT;
      HALT:    if (excp_r.flag) next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  // Redirects ignore ready/stall; idle without a redirect freezes the PC.
  always_comb begin
    pc_next = pc_q;
    unique case (state)
      RUN: begin
        if (excp_r.flag)        pc_next = ADDR_WIDTH'(excp_r.target);
        else if (br_r.flag)     pc_next = ADDR_WIDTH'(br_r.target);
        else if (!idle_i && adv) pc_next = blk_next;
      end
      HALT:    if (excp_r.flag) pc_next = ADDR_WIDTH'(excp_r.target);
      default: pc_next = pc_q;
    endcase
  end

  always_comb begin
    valid_o  = (state == RUN);
    halted_o = (state == HALT);
  end

  assign pc_o   = pc_q;
  assign adef_o = |pc_q[1:0];

  pc_slot_mask #(
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_slot_mask (
    .off       (pc_q[OFF_W+1:2]),
    .slot_mask (slot_mask_o)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with FETCH_WIDTH=2: boot, sequential fetch,
// holds, redirects and their priority, IDLE/HALT, address error and reset.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        excp_flag_i;
  logic [31:0] excp_target_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        idle_i;
  logic        stall_i;
  logic        ready_i;
  logic [31:0] pc_o;
  logic        valid_o;
  logic [1:0]  slot_mask_o;
  logic        adef_o;
  logic        halted_o;

  int errors = 0;
  int checks = 0;

  pc_gen #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h1c00_0000),
    .FETCH_WIDTH(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .excp_flag_i     (excp_flag_i),
    .excp_target_i   (excp_target_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .idle_i          (idle_i),
    .stall_i         (stall_i),
    .ready_i         (ready_i),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .slot_mask_o     (slot_mask_o),
    .adef_o          (adef_o),
    .halted_o        (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; excp_flag_i = 1'b0; excp_target_i = '0;
    branch_flag_i = 1'b0; branch_target_i = '0;
    idle_i = 1'b0; stall_i = 1'b0; ready_i = 1'b1;
    repeat (2) tick();
    checks++; if (pc_o !== 32'h1c000000) begin errors++; $display("FAIL reset_pc: got %h want 1c000000", pc_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    checks++; if (slot_mask_o !== 2'b11) begin errors++; $display("FAIL reset_mask: got %b want 11", slot_mask_o); end
    // A branch during BOOT must be ignored.
    branch_flag_i = 1'b1; branch_target_i = 32'h1c000400;
    rst_n = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", valid_o); end
    tick();
    checks++; if (pc_o !== 32'h1c000000) begin errors++; $display("FAIL boot_ignores_branch: got %h want 1c000000", pc_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL run_valid: got %b want 1", valid_o); end
    branch_flag_i = 1'b0;
  endtask

  task automatic test_sequential;
    tick();
    checks++; if (pc_o !== 32'h1c000008) begin errors++; $display("FAIL seq_pc1: got %h want 1c000008", pc_o); end
    checks++; if (slot_mask_o !== 2'b11) begin errors++; $display("FAIL seq_mask1: got %b want 11", slot_mask_o); end
  endtask

  task automatic test_hold;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_o !== 32'h1c000008 || valid_o !== 1'b1) begin
        errors++; $display("FAIL hold_not_ready[%0d]: got pc=%h valid=%b want 1c000008/1", i, pc_o, valid_o); end
    end
    ready_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_o !== 32'h1c000008 || valid_o !== 1'b1) begin
        errors++; $display("FAIL hold_stall[%0d]: got pc=%h valid=%b want 1c000008/1", i, pc_o, valid_o); end
    end
    stall_i = 1'b0;
    tick();
    checks++; if (pc_o !== 32'h1c000010) begin errors++; $display("FAIL seq_pc2: got %h want 1c000010", pc_o); end
    checks++; if (slot_mask_o !== 2'b11) begin errors++; $display("FAIL seq_mask2: got %b want 11", slot_mask_o); end
  endtask

  task automatic test_branch;
    ready_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h1c000104;
    tick();
    checks++; if (pc_o !== 32'h1c000104) begin errors++; $display("FAIL branch_pc: got %h want 1c000104", pc_o); end
    checks++; if (slot_mask_o !== 2'b10) begin errors++; $display("FAIL branch_mask: got %b want 10", slot_mask_o); end
    branch_flag_i = 1'b0; ready_i = 1'b1;
    tick();
    checks++; if (pc_o !== 32'h1c000108) begin errors++; $display("FAIL branch_next_pc: got %h want 1c000108", pc_o); end
    checks++; if (slot_mask_o !== 2'b11) begin errors++; $display("FAIL branch_next_mask: got %b want 11", slot_mask_o); end
  endtask

  task automatic test_priority;
    excp_flag_i = 1'b1; excp_target_i = 32'h1c008000;
    branch_flag_i = 1'b1; branch_target_i = 32'h1c000200;
    tick();
    checks++; if (pc_o !== 32'h1c008000) begin errors++; $display("FAIL excp_over_branch: got %h want 1c008000", pc_o); end
    excp_flag_i = 1'b0; branch_flag_i = 1'b0;
    tick();
    checks++; if (pc_o !== 32'h1c008008) begin errors++; $display("FAIL after_excp_adv: got %h want 1c008008", pc_o); end
  endtask

  task automatic test_idle;
    idle_i = 1'b1;
    tick();
    checks++; if (halted_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL idle_halt: got halted=%b valid=%b want 1/0", halted_o, valid_o); end
    checks++; if (pc_o !== 32'h1c008008) begin errors++; $display("FAIL idle_pc_hold: got %h want 1c008008", pc_o); end
    branch_flag_i = 1'b1; branch_target_i = 32'h1c000200;
    tick();
    checks++; if (pc_o !== 32'h1c008008 || halted_o !== 1'b1) begin
      errors++; $display("FAIL halt_ignores_branch: got pc=%h halted=%b want 1c008008/1", pc_o, halted_o); end
    branch_flag_i = 1'b0; idle_i = 1'b0;
    excp_flag_i = 1'b1; excp_target_i = 32'h1c008000;
    tick();
    checks++; if (halted_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++; $display("FAIL excp_wake: got halted=%b valid=%b want 0/1", halted_o, valid_o); end
    checks++; if (pc_o !== 32'h1c008000) begin errors++; $display("FAIL excp_wake_pc: got %h want 1c008000", pc_o); end
    excp_flag_i = 1'b0;
  endtask

  task automatic test_idle_redirects;
    idle_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h1c000300;
    tick();
    checks++; if (pc_o !== 32'h1c000300 || halted_o !== 1'b1) begin
      errors++; $display("FAIL idle_branch: got pc=%h halted=%b want 1c000300/1", pc_o, halted_o); end
    branch_flag_i = 1'b0; idle_i = 1'b0;
    excp_flag_i = 1'b1; excp_target_i = 32'h1c000040;
    tick();
    checks++; if (pc_o !== 32'h1c000040 || valid_o !== 1'b1) begin
      errors++; $display("FAIL wake2: got pc=%h valid=%b want 1c000040/1", pc_o, valid_o); end
    idle_i = 1'b1; excp_target_i = 32'h1c000080;
    tick();
    checks++; if (pc_o !== 32'h1c000080 || valid_o !== 1'b1 || halted_o !== 1'b0) begin
      errors++; $display("FAIL idle_excp: got pc=%h valid=%b halted=%b want 1c000080/1/0", pc_o, valid_o, halted_o); end
    idle_i = 1'b0; excp_flag_i = 1'b0;
  endtask

  task automatic test_adef_wrap;
    ready_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h1c000002;
    tick();
    checks++; if (pc_o !== 32'h1c000002) begin errors++; $display("FAIL adef_pc: got %h want 1c000002", pc_o); end
    checks++; if (adef_o !== 1'b1) begin errors++; $display("FAIL adef_set: got %b want 1", adef_o); end
    branch_flag_i = 1'b0; ready_i = 1'b1;
    tick();
    checks++; if (pc_o !== 32'h1c000008 || adef_o !== 1'b0) begin
      errors++; $display("FAIL adef_adv: got pc=%h adef=%b want 1c000008/0", pc_o, adef_o); end
    ready_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'hfffffffc;
    tick();
    checks++; if (slot_mask_o !== 2'b10) begin errors++; $display("FAIL top_mask: got %b want 10", slot_mask_o); end
    branch_flag_i = 1'b0; ready_i = 1'b1;
    tick();
    checks++; if (pc_o !== 32'h00000000) begin errors++; $display("FAIL wrap_pc: got %h want 00000000", pc_o); end
  endtask

  task automatic test_async_reset;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_o !== 32'h1c000000) begin errors++; $display("FAIL async_rst_pc: got %h want 1c000000", pc_o); end
    checks++; if (valid_o !== 1'b0 || halted_o !== 1'b0) begin
      errors++; $display("FAIL async_rst_flags: got valid=%b halted=%b want 0/0", valid_o, halted_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_branch();
    test_priority();
    test_idle();
    test_idle_redirects();
    test_adef_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
